mem_bus_arbiter: RTL and testbench

Sequences and shares the single external memory bus port between three requesters: data cache (refill/writeback bursts), uncached data access (the path carrying the data-side uncached flag), and instruction cache refill. One transaction is in flight at a time. Each transaction is an address phase followed by 1–16 data beats. Selection is fixed-priority with an aging guard so instruction refill cannot starve. The block sits between the cache/uncached controllers and the bus bridge.

---
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single external memory bus port between three requesters
//   (0 = dcache, 1 = uncached data, 2 = icache refill). One transaction is in
//   flight at a time: an address phase followed by 1..16 data beats. Winner
//   selection is fixed-priority (lowest index), except that a requester that
//   has lost AGE_MAX consecutive arbitrations is promoted to the top.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rq_req[2:0]       per-requester request, held until its rq_addr_ok
//   rq_wr[2:0]        per-requester write flag
//   rq_addr[95:0]     {addr2, addr1, addr0}
//   rq_len[11:0]      {len2, len1, len0}, beats-1
//   rq_wstrb[11:0]    per-requester byte strobes
//   rq_wdata[95:0]    per-requester write data, current beat
//   rq_addr_ok[2:0]   one-hot pulse, address phase accepted
//   rq_data_ok[2:0]   one-hot pulse, one beat done
//   rq_rdata[31:0]    read data, valid with rq_data_ok
//   rq_last           final beat of the current transaction
//   bus_req/bus_wr/bus_addr/bus_len/bus_wstrb/bus_wdata   bus request side
//   bus_addr_ok/bus_data_ok/bus_rdata                     bus response side
//   busy              transaction in progress
module mem_bus_arbiter #(
    parameter int AGE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rq_req,
    input  logic [2:0]  rq_wr,
    input  logic [95:0] rq_addr,
    input  logic [11:0] rq_len,
    input  logic [11:0] rq_wstrb,
    input  logic [95:0] rq_wdata,
    output logic [2:0]  rq_addr_ok,
    output logic [2:0]  rq_data_ok,
    output logic [31:0] rq_rdata,
    output logic        rq_last,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_len,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  beat_q;
    logic [2:0]  age_q [3];

    logic [1:0]  grant_d;

    // Winner selection: an aged-out requester beats plain priority. Age is
    // only honoured for requesters that are actually asking right now.
    always_comb begin
        logic found;
        grant_d = 2'd0;
        found   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!found && rq_req[i] && (age_q[i] >= AGE_LIM)) begin
                grant_d = 2'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!found && rq_req[i]) begin
                grant_d = 2'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            len_q   <= 4'd0;
            wstrb_q <= 4'd0;
            beat_q  <= 4'd0;
            for (int i = 0; i < 3; i++) age_q[i] <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|rq_req) begin
                        grant_q <= grant_d;
                        wr_q    <= rq_wr[grant_d];
                        addr_q  <= rq_addr[grant_d*32 +: 32];
                        len_q   <= rq_len[grant_d*4 +: 4];
                        wstrb_q <= rq_wstrb[grant_d*4 +: 4];
                        state_q <= ADDR;
                        // Losers that are still asking age (saturating);
                        // the winner and idle requesters start over.
                        for (int i = 0; i < 3; i++) begin
                            if (!rq_req[i] || (grant_d == 2'(i))) begin
                                age_q[i] <= 3'd0;
                            end else if (age_q[i] < AGE_LIM) begin
                                age_q[i] <= age_q[i] + 3'd1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (bus_addr_ok) begin
                        beat_q  <= len_q;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bus_data_ok) begin
                        if (beat_q == 4'd0) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q - 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake pulses are combinational so the requester sees them in the
    // same cycle the bus reports the event.
    logic addr_fire;
    logic data_fire;
    assign addr_fire = (state_q == ADDR) && bus_addr_ok;
    assign data_fire = (state_q == DATA) && bus_data_ok;

    assign bus_req    = (state_q == ADDR);
    assign bus_wr     = wr_q;
    assign bus_addr   = addr_q;
    assign bus_len    = len_q;
    assign bus_wstrb  = wstrb_q;
    assign bus_wdata  = ((state_q == DATA) && wr_q) ? rq_wdata[grant_q*32 +: 32] : 32'd0;
    assign rq_addr_ok = addr_fire ? (3'b001 << grant_q) : 3'b000;
    assign rq_data_ok = data_fire ? (3'b001 << grant_q) : 3'b000;
    assign rq_rdata   = data_fire ? bus_rdata : 32'd0;
    assign rq_last    = data_fire && (beat_q == 4'd0);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rq_req;
    logic [2:0]  rq_wr;
    logic [95:0] rq_addr;
    logic [11:0] rq_len;
    logic [11:0] rq_wstrb;
    logic [95:0] rq_wdata;
    logic [2:0]  rq_addr_ok;
    logic [2:0]  rq_data_ok;
    logic [31:0] rq_rdata;
    logic        rq_last;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_len;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AGE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .rq_req(rq_req), .rq_wr(rq_wr), .rq_addr(rq_addr), .rq_len(rq_len),
        .rq_wstrb(rq_wstrb), .rq_wdata(rq_wdata),
        .rq_addr_ok(rq_addr_ok), .rq_data_ok(rq_data_ok), .rq_rdata(rq_rdata),
        .rq_last(rq_last),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .busy(busy)
    );

    typedef struct {
        logic        is_data;
        logic [2:0]  vec;
        logic [31:0] rdata;
        logic        last;
        logic [31:0] wdata;
    } ev_t;

    ev_t         eq[$];
    logic [40:0] aq[$];
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expectation whenever the DUT shows a handshake.
    always @(negedge clk) begin
        logic [40:0] a;
        ev_t         e;
        if (bus_req && bus_addr_ok) begin
            if (aq.size() == 0) begin
                chk("addr_phase_unexpected", 128'({bus_wr, bus_addr, bus_len, bus_wstrb}), 128'(0) - 128'(1));
            end else begin
                a = aq.pop_front();
                chk("addr_phase", 128'({bus_wr, bus_addr, bus_len, bus_wstrb}), 128'(a));
            end
        end
        if (rq_addr_ok != 3'b000) begin
            if (eq.size() == 0) begin
                chk("addr_ok_unexpected", 128'(rq_addr_ok), 128'(0));
            end else begin
                e = eq.pop_front();
                chk("addr_ok", 128'({1'b0, rq_addr_ok}), 128'({e.is_data, e.vec}));
            end
        end
        if (rq_data_ok != 3'b000) begin
            if (eq.size() == 0) begin
                chk("data_ok_unexpected", 128'(rq_data_ok), 128'(0));
            end else begin
                e = eq.pop_front();
                chk("data_ok", 128'({1'b1, rq_data_ok, rq_rdata, rq_last, bus_wdata}),
                    128'({e.is_data, e.vec, e.rdata, e.last, e.wdata}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [3:0] len, input logic [3:0] wstrb, input logic [31:0] wdata);
        rq_wr[idx]              = wr;
        rq_addr[idx*32 +: 32]   = addr;
        rq_len[idx*4 +: 4]      = len;
        rq_wstrb[idx*4 +: 4]    = wstrb;
        rq_wdata[idx*32 +: 32]  = wdata;
        rq_req[idx]             = 1'b1;
    endtask

    task automatic exp_addr(input int idx, input logic wr, input logic [31:0] addr,
                            input logic [3:0] len, input logic [3:0] wstrb);
        ev_t e;
        aq.push_back({wr, addr, len, wstrb});
        e.is_data = 1'b0; e.vec = 3'b001 << idx; e.rdata = 32'd0; e.last = 1'b0; e.wdata = 32'd0;
        eq.push_back(e);
    endtask

    task automatic exp_beat(input int idx, input logic [31:0] rdata, input logic last,
                            input logic [31:0] wdata);
        ev_t e;
        e.is_data = 1'b1; e.vec = 3'b001 << idx; e.rdata = rdata; e.last = last; e.wdata = wdata;
        eq.push_back(e);
    endtask

    task automatic exp_txn(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [3:0] len, input logic [3:0] wstrb,
                           input logic [31:0] rbase, input logic [31:0] wdata);
        exp_addr(idx, wr, addr, len, wstrb);
        for (int b = 0; b <= int'(len); b++) begin
            exp_beat(idx, rbase + 32'(b), (b == int'(len)), wr ? wdata : 32'd0);
        end
    endtask

    // Bus bridge model: accepts the address at once, then streams beats.
    task automatic serve(input int idx, input bit hold, input int nbeats,
                         input logic [31:0] rbase, output int waited);
        waited = 0;
        while (!bus_req && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus_req) chk("bus_req_timeout", 128'(bus_req), 128'(1));
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        if (!hold) rq_req[idx] = 1'b0;
        bus_data_ok = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            bus_rdata = rbase + 32'(b);
            tick();
        end
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({bus_req, bus_wr, bus_addr, bus_len, bus_wstrb, bus_wdata,
                     rq_addr_ok, rq_data_ok, rq_rdata, rq_last, busy});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int order [6];
        rst = 1'b1;
        rq_req = '0; rq_wr = '0; rq_addr = '0; rq_len = '0; rq_wstrb = '0; rq_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        tick();
        tick();
        chk("reset_outputs", all_outs(), 128'(0));
        rst = 1'b0;
        tick();

        // Single dcache read, 4 beats
        set_req(0, 1'b0, 32'h1fc0_0000, 4'd3, 4'h0, 32'd0);
        exp_txn(0, 1'b0, 32'h1fc0_0000, 4'd3, 4'h0, 32'hA000_0000, 32'd0);
        tick();
        chk("read_latency_bus_req", 128'(bus_req), 128'(1));
        serve(0, 1'b0, 4, 32'hA000_0000, w);
        chk("read_busy_after", 128'(busy), 128'(0));

        // Uncached single-beat write
        set_req(1, 1'b1, 32'hbfaf_8000, 4'd0, 4'hF, 32'h1234_5678);
        exp_txn(1, 1'b1, 32'hbfaf_8000, 4'd0, 4'hF, 32'h0000_0055, 32'h1234_5678);
        serve(1, 1'b0, 1, 32'h0000_0055, w);
        chk("write_latency", 128'(w), 128'(1));

        // All three request at once: grant order 0, 1, 2 with one bubble
        set_req(0, 1'b0, 32'h0000_1000, 4'd1, 4'h0, 32'd0);
        set_req(1, 1'b0, 32'h0000_2000, 4'd1, 4'h0, 32'd0);
        set_req(2, 1'b0, 32'h0000_3000, 4'd1, 4'h0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            exp_txn(i, 1'b0, 32'h0000_1000 * 32'(i + 1), 4'd1, 4'h0, 32'hB000_0000 + 32'(i * 16), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            serve(i, 1'b0, 2, 32'hB000_0000 + 32'(i * 16), w);
            chk("triple_bubble", 128'(w), 128'(1));
        end

        // Starvation: 0 and 2 held; grants 0,0,0,0,2 then 0 (age of 2 cleared)
        order = '{0, 0, 0, 0, 2, 0};
        set_req(0, 1'b0, 32'h0000_4000, 4'd0, 4'h0, 32'd0);
        set_req(2, 1'b0, 32'h0000_8000, 4'd0, 4'h0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            exp_txn(order[k], 1'b0, (order[k] == 0) ? 32'h0000_4000 : 32'h0000_8000,
                    4'd0, 4'h0, 32'hC000_0000 + 32'(k), 32'd0);
        end
        for (int k = 0; k < 6; k++) begin
            serve(order[k], 1'b1, 1, 32'hC000_0000 + 32'(k), w);
        end
        rq_req = 3'b000;
        tick();
        chk("starve_idle_after", 128'(busy), 128'(0));

        // Out-of-phase pulses are ignored
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        chk("addr_ok_in_idle_ignored", 128'(busy), 128'(0));
        set_req(0, 1'b0, 32'h0000_5000, 4'd0, 4'h0, 32'd0);
        exp_txn(0, 1'b0, 32'h0000_5000, 4'd0, 4'h0, 32'hD000_0000, 32'd0);
        tick();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hDEAD_BEEF;
        tick();
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        chk("data_ok_in_addr_ignored", 128'({busy, bus_req}), 128'(2'b11));
        serve(0, 1'b0, 1, 32'hD000_0000, w);

        // Reset during beat 2 of an 8-beat read
        set_req(0, 1'b0, 32'h8000_1000, 4'd7, 4'h0, 32'd0);
        exp_addr(0, 1'b0, 32'h8000_1000, 4'd7, 4'h0);
        exp_beat(0, 32'hE000_0000, 1'b0, 32'd0);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rq_req[0]   = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hE000_0000;
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset_outputs", all_outs(), 128'(0));
        set_req(2, 1'b1, 32'h0000_2000, 4'd0, 4'h3, 32'hCAFE_F00D);
        exp_txn(2, 1'b1, 32'h0000_2000, 4'd0, 4'h3, 32'h0000_0077, 32'hCAFE_F00D);
        serve(2, 1'b0, 1, 32'h0000_0077, w);
        chk("after_reset_latency", 128'(w), 128'(1));
        tick();
        tick();

        chk("events_drained", 128'(eq.size()), 128'(0));
        chk("addr_phases_drained", 128'(aq.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
